// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the word/opcode widths, the RV32I opcode values the encoder understands,
// the canonical NOP (addi x0,x0,0) and the field bundle struct passed to inst_pack.
package inst_encoder_pkg;

   localparam int OPWIDTH  = 7;
   localparam int REGWIDTH = 32;

   localparam logic [REGWIDTH-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [OPWIDTH-1:0] {
      OP_RTYPE  = 7'h33,
      OP_IARITH = 7'h13,
      OP_ILOAD  = 7'h03,
      OP_STYPE  = 7'h23,
      OP_BTYPE  = 7'h63,
      OP_JAL    = 7'h6F,
      OP_JALR   = 7'h67,
      OP_LUI    = 7'h37,
      OP_AUIPC  = 7'h17
   } opcode_e;

   typedef struct packed {
      logic [OPWIDTH-1:0]  opcode;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [REGWIDTH-1:0] imm;
   } fields_t;

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational fields -> 32-bit RV32I instruction word.
// Ports:
//   fields    in   fields_t   opcode/rd/rs1/rs2/funct3/funct7/imm (imm in decoded form)
//   word      out  32         encoded word, or NOP when the bundle is not encodable
//   bad_range out  1          immediate not representable in the opcode's format
//   bad_op    out  1          opcode not supported
module inst_pack
   import inst_encoder_pkg::*;
(
   input  fields_t             fields,
   output logic [REGWIDTH-1:0] word,
   output logic                bad_range,
   output logic                bad_op
);

   logic [31:0] imm;
   logic        fits_12;   // signed 12-bit: [-2048, 2047]
   logic        fits_13e;  // signed 13-bit, even: [-4096, 4094]
   logic        fits_21e;  // signed 21-bit, even: [-2^20, 2^20-2]

   assign imm = fields.imm;

   // A value fits in N signed bits when every bit from N-1 upward equals the sign.
   assign fits_12  = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign fits_13e = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
   assign fits_21e = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

   always_comb begin
      word      = '0;
      bad_range = 1'b0;
      bad_op    = 1'b0;
      case (fields.opcode)
         OP_RTYPE:
            word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
         OP_IARITH, OP_ILOAD: begin
            bad_range = !fits_12;
            word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
         end
         OP_JALR: begin
            // JALR offset is treated as unsigned here; funct3 is fixed at 0.
            bad_range = (imm[31:12] != '0);
            word = {imm[11:0], fields.rs1, 3'b000, fields.rd, fields.opcode};
         end
         OP_STYPE: begin
            bad_range = !fits_12;
            word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
         end
         OP_BTYPE: begin
            bad_range = !fits_13e;
            word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                    imm[4:1], imm[11], fields.opcode};
         end
         OP_JAL: begin
            bad_range = !fits_21e;
            word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
         end
         OP_LUI, OP_AUIPC: begin
            bad_range = (imm[11:0] != '0);
            word = {imm[31:12], fields.rd, fields.opcode};
         end
         default: bad_op = 1'b1;
      endcase
      if (bad_range || bad_op) word = NOP_INST;
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streams encoded RV32I words with sequential byte addresses.
// One output register stage with valid/ready on both sides.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clr                   clears error flags, count, and address (to BASE_ADDR)
//   in_valid / in_ready   input handshake for the field bundle
//   opcode,rd,rs1,rs2,funct3,funct7,imm   instruction fields (imm in decoded form)
//   out_valid / out_ready output handshake
//   out_inst, out_addr    encoded word and its byte address
//   count                 words emitted, saturating at 16'hFFFF
//   err_range, err_opcode sticky error flags
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPWIDTH-1:0]  opcode,
   input  logic [4:0]          rd,
   input  logic [4:0]          rs1,
   input  logic [4:0]          rs2,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic [REGWIDTH-1:0] imm,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [REGWIDTH-1:0] out_inst,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [15:0]         count,
   output logic                err_range,
   output logic                err_opcode
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   fields_t             fields;
   logic [REGWIDTH-1:0] word;
   logic                bad_range;
   logic                bad_op;
   logic                accept;
   logic                fire;

   assign fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                     funct3: funct3, funct7: funct7, imm: imm};

   inst_pack u_pack (
      .fields    (fields),
      .word      (word),
      .bad_range (bad_range),
      .bad_op    (bad_op)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign fire     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_inst   <= '0;
         out_addr   <= BASE;
         count      <= '0;
         err_range  <= 1'b0;
         err_opcode <= 1'b0;
      end else begin
         // A new word may replace the one draining this cycle.
         if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= word;
         end else if (fire) begin
            out_valid <= 1'b0;
         end

         // out_addr always names the word currently (or next) on the output,
         // so it only moves when a word leaves. clr re-addresses a pending word.
         if (clr) begin
            out_addr <= BASE;
            count    <= '0;
         end else if (fire) begin
            out_addr <= out_addr + ADDR_W'(4);
            if (count != 16'hFFFF) count <= count + 16'd1;
         end

         if (clr) begin
            err_range  <= 1'b0;
            err_opcode <= 1'b0;
         end else if (accept) begin
            err_range  <= err_range  | bad_range;
            err_opcode <= err_opcode | bad_op;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors plus randomized traffic
// against a behavioural model. Two instances share the inputs: one with the
// default 10-bit address and BASE_ADDR=256, one with a 4-bit address for wrap.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   localparam int BASE = 256;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, out_ready;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm;

   logic        in_ready, out_valid, err_range, err_opcode;
   logic [31:0] out_inst;
   logic [9:0]  out_addr;
   logic [15:0] count;

   logic        in_ready_w, out_valid_w, err_range_w, err_opcode_w;
   logic [31:0] out_inst_w;
   logic [3:0]  out_addr_w;
   logic [15:0] count_w;

   always #5 clk = ~clk;

   inst_encoder #(.ADDR_W(10), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_addr(out_addr), .count(count), .err_range(err_range), .err_opcode(err_opcode));

   inst_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_w (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .out_valid(out_valid_w), .out_ready(out_ready), .out_inst(out_inst_w),
      .out_addr(out_addr_w), .count(count_w), .err_range(err_range_w),
      .err_opcode(err_opcode_w));

   int checks = 0;
   int errors = 0;

   // Model state: what the outputs should show after the latest edge.
   bit          mv;
   logic [31:0] mw;
   int          maddr, maddr_w, mcnt;
   bit          mre, moe;

   // Reference encoder built from field positions with shifts and masks,
   // range rules checked as signed integers.
   function automatic void ref_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] im, output logic [31:0] w,
                                   output bit re, output bit oe);
      int          si;
      logic [31:0] D, S1, S2, F3, F7, OP;
      si = $signed(im);
      D = 32'(d); S1 = 32'(s1); S2 = 32'(s2); F3 = 32'(f3); F7 = 32'(f7); OP = 32'(op);
      re = 0; oe = 0; w = 0;
      case (op)
         7'h33: w = (F7 << 25) | (S2 << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | OP;
         7'h13, 7'h03: begin
            re = (si < -2048) || (si > 2047);
            w = ((im & 32'hFFF) << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | OP;
         end
         7'h67: begin
            re = (im >= 32'd4096);
            w = ((im & 32'hFFF) << 20) | (S1 << 15) | (D << 7) | OP;
         end
         7'h23: begin
            re = (si < -2048) || (si > 2047);
            w = (((im >> 5) & 32'h7F) << 25) | (S2 << 20) | (S1 << 15) | (F3 << 12)
              | ((im & 32'h1F) << 7) | OP;
         end
         7'h63: begin
            re = (si < -4096) || (si > 4094) || (im % 2 != 0);
            w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (S2 << 20)
              | (S1 << 15) | (F3 << 12) | (((im >> 1) & 32'hF) << 8)
              | (((im >> 11) & 1) << 7) | OP;
         end
         7'h6F: begin
            re = (si < -(1 << 20)) || (si > (1 << 20) - 2) || (im % 2 != 0);
            w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
              | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (D << 7) | OP;
         end
         7'h37, 7'h17: begin
            re = (im % 4096 != 0);
            w = (im & 32'hFFFF_F000) | (D << 7) | OP;
         end
         default: oe = 1;
      endcase
      if (re || oe) w = 32'h13;
   endfunction

   // Advance the model with the inputs currently driven, then clock.
   task automatic tick();
      bit          ir, acc, fire, re, oe;
      logic [31:0] w;
      ir   = !mv || out_ready;
      acc  = in_valid && ir;
      fire = mv && out_ready;
      ref_enc(opcode, rd, rs1, rs2, funct3, funct7, imm, w, re, oe);
      @(posedge clk); #1;
      if (rst) begin
         mv = 0; mw = 0; maddr = BASE; maddr_w = 0; mcnt = 0; mre = 0; moe = 0;
      end else begin
         if (acc) begin mv = 1; mw = w; end
         else if (fire) mv = 0;
         if (clr) begin
            maddr = BASE; maddr_w = 0; mcnt = 0; mre = 0; moe = 0;
         end else begin
            if (fire) begin
               maddr = (maddr + 4) % 1024; maddr_w = (maddr_w + 4) % 16;
               if (mcnt < 65535) mcnt++;
            end
            if (acc) begin mre |= re; moe |= oe; end
         end
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im);
      opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
   endtask

   task automatic do_clr();
      in_valid = 0; out_ready = 1; clr = 1; tick(); clr = 0;
   endtask

   task automatic test_reset();
      rst = 1; clr = 0; in_valid = 0; out_ready = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); rst = 0; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", out_inst); end
      checks++; if (out_addr !== 10'(BASE)) begin errors++; $display("FAIL reset_addr got %0d want %0d", out_addr, BASE); end
      checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if ({err_range, err_opcode} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {err_range, err_opcode}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_encodings();
      logic [6:0]  ops [5] = '{7'h13, 7'h23, 7'h63, 7'h6F, 7'h37};
      logic [4:0]  rds [5] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd5};
      logic [4:0]  r1s [5] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0};
      logic [4:0]  r2s [5] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
      logic [2:0]  f3s [5] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
      logic [31:0] ims [5] = '{32'd5, 32'd8, 32'hFFFF_FFFC, 32'd2048, 32'h1234_5000};
      logic [31:0] exp [5] = '{32'h0050_0093, 32'h0020_A423, 32'hFE00_0EE3, 32'h0010_00EF, 32'h1234_52B7};
      do_clr();
      for (int i = 0; i < 5; i++) begin
         drive(ops[i], rds[i], r1s[i], r2s[i], f3s[i], 7'd0, ims[i]);
         in_valid = 1; out_ready = 1; tick();
         checks++; if (out_valid !== 1'b1 || out_inst !== exp[i]) begin errors++; $display("FAIL enc_%0d got v=%0b %h want %h", i, out_valid, out_inst, exp[i]); end
         checks++; if (out_addr !== 10'(BASE + 4 * i)) begin errors++; $display("FAIL enc_addr_%0d got %0d want %0d", i, out_addr, BASE + 4 * i); end
      end
      in_valid = 0; tick();
      checks++; if (count !== 16'd5) begin errors++; $display("FAIL enc_count got %0d want 5", count); end
   endtask

   task automatic test_errors();
      do_clr();
      drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      in_valid = 1; tick();
      checks++; if (out_inst !== 32'h13 || err_range !== 1'b1 || err_opcode !== 1'b0) begin errors++; $display("FAIL err_range_nop got %h r=%0b o=%0b want 00000013 r=1 o=0", out_inst, err_range, err_opcode); end
      drive(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'd0);
      tick();
      checks++; if (out_inst !== 32'h13 || err_opcode !== 1'b1 || err_range !== 1'b1) begin errors++; $display("FAIL err_op_nop got %h r=%0b o=%0b want 00000013 r=1 o=1", out_inst, err_range, err_opcode); end
      checks++; if (out_addr !== 10'(BASE + 4)) begin errors++; $display("FAIL err_addr got %0d want %0d", out_addr, BASE + 4); end
      do_clr();
      checks++; if ({err_range, err_opcode} !== 2'b00 || out_addr !== 10'(BASE)) begin errors++; $display("FAIL err_clr got %b addr %0d want 00 addr %0d", {err_range, err_opcode}, out_addr, BASE); end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      int          c0, a0;
      drive(7'h13, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
      in_valid = 1; out_ready = 0; tick();
      held = out_inst;
      checks++; if (held !== 32'h0641_0393) begin errors++; $display("FAIL stall_first got %h want 06410393", held); end
      drive(7'h13, 5'd8, 5'd2, 5'd0, 3'd0, 7'd0, 32'd200);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0 || out_inst !== held || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d got rdy=%0b %h want rdy=0 %h", k, in_ready, out_inst, held); end
         tick();
      end
      out_ready = 1; c0 = count; a0 = out_addr;
      for (int k = 1; k <= 3; k++) begin
         drive(7'h33, 5'(k), 5'(k + 1), 5'(k + 2), 3'd0, 7'h20, 32'd0);
         tick();
         checks++; if (count !== 16'(c0 + k) || out_addr !== 10'((a0 + 4 * k) % 1024)) begin errors++; $display("FAIL stall_release_%0d got cnt=%0d addr=%0d want cnt=%0d addr=%0d", k, count, out_addr, c0 + k, (a0 + 4 * k) % 1024); end
         checks++; if (out_inst !== mw) begin errors++; $display("FAIL stall_word_%0d got %h want %h", k, out_inst, mw); end
      end
      in_valid = 0; tick();
   endtask

   task automatic test_wrap_and_rst();
      do_clr();
      in_valid = 1; out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         drive(7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
         tick();
         checks++; if (out_addr_w !== 4'((4 * k) % 16)) begin errors++; $display("FAIL wrap_addr_%0d got %0d want %0d", k, out_addr_w, (4 * k) % 16); end
      end
      out_ready = 0; tick();
      rst = 1; tick(); rst = 0; in_valid = 0; #1;
      checks++; if (out_valid !== 1'b0 || out_valid_w !== 1'b0 || out_inst !== 32'h0) begin errors++; $display("FAIL rst_mid got v=%0b vw=%0b %h want 0 0 0", out_valid, out_valid_w, out_inst); end
      checks++; if (out_addr !== 10'(BASE) || count !== 16'h0 || out_addr_w !== 4'h0) begin errors++; $display("FAIL rst_mid_addr got %0d cnt %0d want %0d 0", out_addr, count, BASE); end
   endtask

   function automatic logic [31:0] rand_imm();
      case ($urandom % 6)
         0: return $urandom;
         1: return 32'($signed($urandom_range(0, 4095)) - 2048);
         2: return 32'($signed($urandom_range(0, 8191)) - 4096);
         3: return 32'($signed($urandom_range(0, (1 << 21) - 1)) - (1 << 20));
         4: return $urandom & 32'hFFFF_F000;
         default: return 32'($urandom_range(0, 4500));
      endcase
   endfunction

   task automatic test_random();
      logic [6:0] opl [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
      for (int n = 0; n < 400; n++) begin
         drive(opl[$urandom % 11], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
               7'($urandom), rand_imm());
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         clr       = ($urandom % 60) == 0;
         #1;
         checks++; if (in_ready !== (!mv || out_ready) || in_ready_w !== in_ready) begin errors++; $display("FAIL rnd_ready_%0d got %0b want %0b", n, in_ready, !mv || out_ready); end
         tick();
         clr = 0;
         checks++; if (out_valid !== mv || (mv && out_inst !== mw)) begin errors++; $display("FAIL rnd_word_%0d got v=%0b %h want v=%0b %h", n, out_valid, out_inst, mv, mw); end
         checks++; if (out_addr !== 10'(maddr) || out_addr_w !== 4'(maddr_w)) begin errors++; $display("FAIL rnd_addr_%0d got %0d/%0d want %0d/%0d", n, out_addr, out_addr_w, maddr, maddr_w); end
         checks++; if (count !== 16'(mcnt) || err_range !== mre || err_opcode !== moe) begin errors++; $display("FAIL rnd_state_%0d got cnt=%0d r=%0b o=%0b want cnt=%0d r=%0b o=%0b", n, count, err_range, err_opcode, mcnt, mre, moe); end
      end
   endtask

   initial begin
      test_reset();
      test_encodings();
      test_errors();
      test_stall();
      test_wrap_and_rst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
